// File: rtl/gcn_pkg.sv
// Shared types and default widths for the GCN argmax stage.
package gcn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } argmax_state_t;

    localparam int GCN_DOT_PROD_WIDTH    = 16;
    localparam int GCN_MAX_ADDRESS_WIDTH = 2;
    localparam int GCN_WEIGHT_COLS       = 3;
    localparam int GCN_FEATURE_ROWS      = 6;

endpackage

// File: rtl/gcn_argmax_cmp.sv
// Compare-and-select step of the argmax: keeps the running best unless the candidate is strictly larger.
module gcn_argmax_cmp
    import gcn_pkg::*;
#(
    parameter int VAL_WIDTH = GCN_DOT_PROD_WIDTH,
    parameter int IDX_WIDTH = GCN_MAX_ADDRESS_WIDTH
) (
    input  logic [VAL_WIDTH-1:0] best_val,
    input  logic [IDX_WIDTH-1:0] best_idx,
    input  logic [VAL_WIDTH-1:0] cand_val,
    input  logic [IDX_WIDTH-1:0] cand_idx,
    output logic [VAL_WIDTH-1:0] new_val,
    output logic [IDX_WIDTH-1:0] new_idx
);

    logic take;

    // Strict greater-than so equal values keep the earlier (lower) index.
    assign take    = cand_val > best_val;
    assign new_val = take ? cand_val : best_val;
    assign new_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/gcn_argmax_block.sv
// Final GCN stage: per-node argmax over aggregated rows, one column per cycle.
// Optional feature macro GCN_ARGMAX_MAXVAL_EN adds the per-node max_val output.
module gcn_argmax_block
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS      = GCN_FEATURE_ROWS,
    parameter int WEIGHT_COLS       = GCN_WEIGHT_COLS,
    parameter int DOT_PROD_WIDTH    = GCN_DOT_PROD_WIDTH,
    parameter int MAX_ADDRESS_WIDTH = GCN_MAX_ADDRESS_WIDTH,
    parameter int ROW_CNT_WIDTH     = $clog2(FEATURE_ROWS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DOT_PROD_WIDTH-1:0]    adj_row         [0:WEIGHT_COLS-1],
    output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
`ifdef GCN_ARGMAX_MAXVAL_EN
    output logic [DOT_PROD_WIDTH-1:0]    max_val         [0:FEATURE_ROWS-1],
`endif
    output logic                         done_argmax
);

    localparam logic [MAX_ADDRESS_WIDTH-1:0] LAST_COL = MAX_ADDRESS_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [ROW_CNT_WIDTH-1:0]     LAST_ROW = ROW_CNT_WIDTH'(FEATURE_ROWS - 1);

    argmax_state_t                state_q, state_d;
    logic [DOT_PROD_WIDTH-1:0]    row_buf_q [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0]    row_buf_d [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0]    best_val_q, best_val_d;
    logic [MAX_ADDRESS_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [MAX_ADDRESS_WIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_CNT_WIDTH-1:0]     row_cnt_q, row_cnt_d;
    logic [MAX_ADDRESS_WIDTH-1:0] answer_q [0:FEATURE_ROWS-1];
    logic [MAX_ADDRESS_WIDTH-1:0] answer_d [0:FEATURE_ROWS-1];
`ifdef GCN_ARGMAX_MAXVAL_EN
    logic [DOT_PROD_WIDTH-1:0]    max_val_q [0:FEATURE_ROWS-1];
    logic [DOT_PROD_WIDTH-1:0]    max_val_d [0:FEATURE_ROWS-1];
`endif

    logic [DOT_PROD_WIDTH-1:0]    cand_val;
    logic [DOT_PROD_WIDTH-1:0]    cmp_val;
    logic [MAX_ADDRESS_WIDTH-1:0] cmp_idx;

    always_comb begin
        cand_val = '0;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            if (MAX_ADDRESS_WIDTH'(c) == col_cnt_q) cand_val = row_buf_q[c];
        end
    end

    gcn_argmax_cmp #(
        .VAL_WIDTH (DOT_PROD_WIDTH),
        .IDX_WIDTH (MAX_ADDRESS_WIDTH)
    ) u_cmp (
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .cand_val (cand_val),
        .cand_idx (col_cnt_q),
        .new_val  (cmp_val),
        .new_idx  (cmp_idx)
    );

    always_comb begin
        state_d    = state_q;
        row_buf_d  = row_buf_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        answer_d   = answer_q;
`ifdef GCN_ARGMAX_MAXVAL_EN
        max_val_d  = max_val_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    row_buf_d  = adj_row;
                    best_val_d = adj_row[0];
                    best_idx_d = '0;
                    col_cnt_d  = MAX_ADDRESS_WIDTH'(1);
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                best_val_d = cmp_val;
                best_idx_d = cmp_idx;
                col_cnt_d  = col_cnt_q + 1'b1;
                // Last column: commit this cycle's winner straight from the comparator.
                if (col_cnt_q == LAST_COL) begin
                    for (int r = 0; r < FEATURE_ROWS; r++) begin
                        if (ROW_CNT_WIDTH'(r) == row_cnt_q) begin
                            answer_d[r] = cmp_idx;
`ifdef GCN_ARGMAX_MAXVAL_EN
                            max_val_d[r] = cmp_val;
`endif
                        end
                    end
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = (row_cnt_q == LAST_ROW) ? DONE : IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_buf_q  <= '{default: '0};
            best_val_q <= '0;
            best_idx_q <= '0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            answer_q   <= '{default: '0};
`ifdef GCN_ARGMAX_MAXVAL_EN
            max_val_q  <= '{default: '0};
`endif
        end else begin
            state_q    <= state_d;
            row_buf_q  <= row_buf_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            answer_q   <= answer_d;
`ifdef GCN_ARGMAX_MAXVAL_EN
            max_val_q  <= max_val_d;
`endif
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign done_argmax     = (state_q == DONE);
    assign max_addi_answer = answer_q;
`ifdef GCN_ARGMAX_MAXVAL_EN
    assign max_val         = max_val_q;
`endif

endmodule
